key_event_decoder: RTL and testbench
====================================

Name: key_event_decoder

Overview:
- Parametrised successor to the hard-coded key-to-pulse logic in the game top level.
- Consumes the 11-bit `key_event` stream from `keyboard`.
- Maps NUM_KEYS configurable {extended, scancode} bindings to per-key press pulses, release pulses and held levels.
- Suppresses typematic repeats; optionally generates its own auto-repeat. Sits between `keyboard` and the game/menu logic, all on `clk`.

Parameters:
- NUM_KEYS, 14: number of bindings, 1..32.
- KEY_MAP, 9*NUM_KEYS bits: entry i at [9i+8:9i] = {ext, code[7:0]}. Default packs, for i = 0..13: W, A, S, D, ↑(E0 75), ←(E0 6B), ↓(E0 72), →(E0 74), P, Space, R, Enter, 1, KP1.
- REPEAT_DELAY, 50_000_000: cycles from press to first auto-repeat (AUTO_REPEAT_EN only).
- REPEAT_PERIOD, 10_000_000: cycles between auto-repeats.
- CNT_W, $clog2(REPEAT_DELAY+1): timer width, derived.

Ports:
- clk  in  1  system clock (100 MHz domain).
- rst  in  1  synchronous active-high reset.
- key_event  in  11  [10] valid strobe (one cycle per decoded code), [9] extended (E0), [8] break (F0), [7:0] scancode.
- clear_all  in  1  force-release all held keys (pause, focus loss).
- press  out  NUM_KEYS  one-cycle pulse per new press (and per auto-repeat).
- release  out  NUM_KEYS  one-cycle pulse on release.
- held  out  NUM_KEYS  level, key currently down.
- any_press  out  1  OR of press.
- unmapped  out  1  one-cycle pulse: valid make matching no binding.
- last_code  out  9  {ext, code} of last accepted valid event.

Behaviour:
- **Reset:** all outputs 0, last_code 9'h000, timer idle.
- **Event acceptance:** accepted on any cycle with key_event[10]=1. Binding i matches when {key_event[9], key_event[7:0]} == KEY_MAP entry i. Multiple matching entries all respond. All outputs are registered, one cycle latency after acceptance.
- **Make ([8]=0), matched i:**
  - If held[i]=0: held[i]<=1 and press[i] pulses.
  - If held[i]=1 (typematic repeat): no pulse.
- **Break ([8]=1), matched i:**
  - If held[i]=1: held[i]<=0 and release[i] pulses.
  - Break of a non-held key: ignored.
- **Unmapped:** make with no match pulses unmapped. Breaks never pulse it.
- **last_code:** updated on every accepted event, make or break, mapped or not.
- **clear_all:** every held bit clears and release pulses for each key that was held. Same-cycle event is dropped (clear_all wins); timer returns to idle.
- **Simultaneous keys:** held bits are independent, so any chord is tracked.
- **Pulse width:** press and release are never high for more than one consecutive cycle, except auto-repeat spacing ≥ REPEAT_PERIOD.

Optional Feature:
- Macro: KEY_AUTO_REPEAT_EN.
- **Defined:** one shared timer tracks the most recently pressed mapped key k.
  - States: IDLE → DELAY on new press of k (counter loads REPEAT_DELAY-1).
  - DELAY → REPEAT at count 0: press[k] pulses, counter loads REPEAT_PERIOD-1.
  - REPEAT at 0: press[k] pulses, counter reloads.
  - Release of k, clear_all or reset → IDLE.
  - A new press of a different key retargets to that key and restarts DELAY.
  - Upstream typematic makes do not restart the timer.
- **Undefined:** no timer logic; press fires only on genuine presses.

Decomposition:
- Package `kbd_pkg`:
  - Event bit indices: VALID=10, EXT=9, BRK=8.
  - Scancode localparams: SC_W 1D, SC_A 1C, SC_S 1B, SC_D 23, SC_UP 75, SC_LEFT 6B, SC_DOWN 72, SC_RIGHT 74, SC_P 4D, SC_SPACE 29, SC_R 2D, SC_ENTER 5A, SC_1 16, SC_KP1 69.
  - Helper function packing {ext, code} into a KEY_MAP entry.
- Sub-module `key_repeat_timer` (counter + 3-state FSM, target index, fire pulse), instantiated only under KEY_AUTO_REPEAT_EN.

Test Plan:
- Reset, then valid make 0_1D → one cycle later press[0]=1 for exactly 1 cycle, held[0]=1, any_press=1, last_code=9'h01D.
- Three more 0_1D makes (typematic) → no press pulse; then break 1_1D (bit8=1) → release[0] one-cycle pulse, held[0]=0.
- Make E0 75 (key_event=11'h675) → press[4]. Make 75 without E0 (11'h475) → unmapped pulse, press stays 0. Break of W while not held → no release.
- Hold W, ↑ and Space, then assert clear_all in the same cycle as make 0_23 → release[0], [4], [9] pulse together; held=0; D is not pressed.
- KEY_AUTO_REPEAT_EN, REPEAT_DELAY=10, REPEAT_PERIOD=4:
  - Make A → press[1] at t+1, t+11, t+15, t+19.
  - Make D at t+20 → press[3] at t+21, t+31; no further press[1].
  - Break D → repeats stop.
- Reset asserted mid-DELAY with keys held → all outputs 0 the next cycle, no release pulses, no repeats afterwards.

Source files
------------

// File: rtl/kbd_pkg.sv
// Shared key-event field indices, PS/2 set-2 scancodes and the default binding table
// for key_event_decoder.
package kbd_pkg;

  localparam int VALID = 10;
  localparam int EXT   = 9;
  localparam int BRK   = 8;

  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_P     = 8'h4D;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_R     = 8'h2D;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_1     = 8'h16;
  localparam logic [7:0] SC_KP1   = 8'h69;

  function automatic logic [8:0] key_entry(input logic ext, input logic [7:0] code);
    return {ext, code};
  endfunction

  // Entry 0 sits in the least significant nine bits.
  localparam logic [125:0] DEFAULT_KEY_MAP = {
    key_entry(1'b0, SC_KP1),   key_entry(1'b0, SC_1),
    key_entry(1'b0, SC_ENTER), key_entry(1'b0, SC_R),
    key_entry(1'b0, SC_SPACE), key_entry(1'b0, SC_P),
    key_entry(1'b1, SC_RIGHT), key_entry(1'b1, SC_DOWN),
    key_entry(1'b1, SC_LEFT),  key_entry(1'b1, SC_UP),
    key_entry(1'b0, SC_D),     key_entry(1'b0, SC_S),
    key_entry(1'b0, SC_A),     key_entry(1'b0, SC_W)
  };

endpackage

// File: rtl/key_event_decoder_if.sv
// Bundle between the keyboard front end (master) and key_event_decoder (slave).
interface key_event_decoder_if #(
  parameter int NUM_KEYS = 14
);
  logic [10:0]         key_event;
  logic                clear_all;
  logic [NUM_KEYS-1:0] press;
  logic [NUM_KEYS-1:0] release_pulse;
  logic [NUM_KEYS-1:0] held;
  logic                any_press;
  logic                unmapped;
  logic [8:0]          last_code;

  modport master (
    output key_event, clear_all,
    input  press, release_pulse, held, any_press, unmapped, last_code
  );

  modport slave (
    input  key_event, clear_all,
    output press, release_pulse, held, any_press, unmapped, last_code
  );
endinterface

// File: rtl/key_repeat_timer.sv
// Shared auto-repeat timer: follows the most recently pressed key and emits a fire
// strobe after REPEAT_DELAY cycles, then every REPEAT_PERIOD cycles until released.
module key_repeat_timer #(
  parameter int NUM_KEYS      = 14,
  parameter int REPEAT_DELAY  = 50_000_000,
  parameter int REPEAT_PERIOD = 10_000_000,
  parameter int CNT_W         = $clog2(REPEAT_DELAY + 1),
  parameter int IDX_W         = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                start,
  input  logic [IDX_W-1:0]    start_idx,
  input  logic [NUM_KEYS-1:0] release_vec,
  output logic                fire,
  output logic [IDX_W-1:0]    target
);
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DELAY  = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             tgt_rel;

  assign tgt_rel = release_vec[target];
  // A retarget, release or clear in the same cycle swallows the pending repeat.
  assign fire = (state != ST_IDLE) && (cnt == '0) && !clear && !start && !tgt_rel;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      target <= '0;
    end else if (clear) begin
      state <= ST_IDLE;
    end else if (start) begin
      state  <= ST_DELAY;
      target <= start_idx;
      cnt    <= CNT_W'(REPEAT_DELAY - 1);
    end else if (tgt_rel) begin
      state <= ST_IDLE;
    end else if (state != ST_IDLE) begin
      if (cnt == '0) begin
        state <= ST_REPEAT;
        cnt   <= CNT_W'(REPEAT_PERIOD - 1);
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end
endmodule

// File: rtl/key_event_decoder.sv
// Maps keyboard events onto per-key press/release pulses and held levels.
// Build with KEY_AUTO_REPEAT_EN defined to add the shared auto-repeat timer.
module key_event_decoder
  import kbd_pkg::*;
#(
  parameter int                    NUM_KEYS      = 14,
  parameter logic [9*NUM_KEYS-1:0] KEY_MAP       = DEFAULT_KEY_MAP,
  parameter int                    REPEAT_DELAY  = 50_000_000,
  parameter int                    REPEAT_PERIOD = 10_000_000,
  parameter int                    CNT_W         = $clog2(REPEAT_DELAY + 1)
) (
  input  logic               clk,
  input  logic               rst,
  key_event_decoder_if.slave bus
);
  localparam int IDX_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;

  if (NUM_KEYS < 1 || NUM_KEYS > 32 || REPEAT_PERIOD < 1 ||
      REPEAT_PERIOD > REPEAT_DELAY || CNT_W < 1) begin : g_bad_cfg
    $error("key_event_decoder: unsupported parameter combination");
  end

  logic                valid, is_brk;
  logic [8:0]          ev_key, last_code_n;
  logic [NUM_KEYS-1:0] hit, new_press, press_n, release_n, held_n, rep_vec;
  logic                unmapped_n;

  logic [NUM_KEYS-1:0] press_p1, release_p1, held_p1;
  logic                any_press_p1, unmapped_p1;
  logic [8:0]          last_code_p1;

  always_comb begin
    valid  = bus.key_event[VALID] & ~bus.clear_all;
    is_brk = bus.key_event[BRK];
    ev_key = {bus.key_event[EXT], bus.key_event[7:0]};
    hit    = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      hit[i] = valid && (ev_key == KEY_MAP[9*i +: 9]);
    end
    new_press   = is_brk ? '0 : (hit & ~held_p1);
    release_n   = bus.clear_all ? held_p1 : (is_brk ? (hit & held_p1) : '0);
    held_n      = bus.clear_all ? '0 : ((held_p1 | new_press) & ~release_n);
    unmapped_n  = valid && !is_brk && (hit == '0);
    last_code_n = valid ? ev_key : last_code_p1;
    press_n     = new_press | rep_vec;
  end

`ifdef KEY_AUTO_REPEAT_EN
  logic [IDX_W-1:0] start_idx, target;
  logic             fire;

  // When one event matches several bindings, the lowest index owns the timer.
  always_comb begin
    start_idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (new_press[i]) start_idx = IDX_W'(i);
    end
    rep_vec = '0;
    if (fire) rep_vec[target] = 1'b1;
  end

  key_repeat_timer #(
    .NUM_KEYS      (NUM_KEYS),
    .REPEAT_DELAY  (REPEAT_DELAY),
    .REPEAT_PERIOD (REPEAT_PERIOD),
    .CNT_W         (CNT_W),
    .IDX_W         (IDX_W)
  ) u_timer (
    .clk         (clk),
    .rst         (rst),
    .clear       (bus.clear_all),
    .start       (|new_press),
    .start_idx   (start_idx),
    .release_vec (release_n),
    .fire        (fire),
    .target      (target)
  );
`else
  assign rep_vec = '0;
`endif

  // Output register stage: every output follows its accepted event by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      press_p1     <= '0;
      release_p1   <= '0;
      held_p1      <= '0;
      any_press_p1 <= 1'b0;
      unmapped_p1  <= 1'b0;
      last_code_p1 <= 9'h000;
    end else begin
      press_p1     <= press_n;
      release_p1   <= release_n;
      held_p1      <= held_n;
      any_press_p1 <= |press_n;
      unmapped_p1  <= unmapped_n;
      last_code_p1 <= last_code_n;
    end
  end

  assign bus.press         = press_p1;
  assign bus.release_pulse = release_p1;
  assign bus.held          = held_p1;
  assign bus.any_press     = any_press_p1;
  assign bus.unmapped      = unmapped_p1;
  assign bus.last_code     = last_code_p1;
endmodule

// File: tb/tb_key_event_decoder.sv
// Scoreboard bench for key_event_decoder with the default 14-key binding table.
module tb_key_event_decoder;
  localparam int NK  = 14;
  localparam int DLY = 10;
  localparam int PER = 4;

  typedef struct packed {
    logic        r;
    logic        clr;
    logic [10:0] ev;
    logic [7:0]  n;
  } stim_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  key_event_decoder_if #(.NUM_KEYS(NK)) bus ();

  key_event_decoder #(
    .NUM_KEYS      (NK),
    .REPEAT_DELAY  (DLY),
    .REPEAT_PERIOD (PER)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [8:0] tb_map [NK] = '{9'h01D, 9'h01C, 9'h01B, 9'h023, 9'h175, 9'h16B, 9'h172,
                              9'h174, 9'h04D, 9'h029, 9'h02D, 9'h05A, 9'h016, 9'h069};

  logic [52:0] obs;
  assign obs = {bus.press, bus.release_pulse, bus.held, bus.any_press, bus.unmapped, bus.last_code};

  logic [52:0] sb [$];
  logic [52:0] exp_v;
  int checks = 0;
  int errors = 0;

  logic [NK-1:0] m_held = '0;
  logic [8:0]    m_last = '0;
  logic          m_rep_on = 1'b0;
  int            m_tgt = 0;
  int            m_t0 = 0;
  int            m_cyc = 0;

  // Drive one cycle of stimulus, push the predicted registered outputs, wait for the edge.
  task automatic cycle(input logic r, input logic clr, input logic [10:0] ev);
    logic [NK-1:0] p, rl, h, nw;
    logic un, valid, hit;
    logic [8:0] lc;
    int el;
    p = '0; rl = '0; h = m_held; nw = '0; un = 1'b0; lc = m_last;
    if (r) begin
      h = '0; lc = '0; m_rep_on = 1'b0;
    end else begin
      valid = ev[10] && !clr;
      hit = 1'b0;
      for (int i = 0; i < NK; i++) begin
        if (valid && {ev[9], ev[7:0]} == tb_map[i]) begin
          hit = 1'b1;
          if (!ev[8] && !m_held[i]) begin p[i] = 1'b1; nw[i] = 1'b1; h[i] = 1'b1; end
          else if (ev[8] && m_held[i]) begin rl[i] = 1'b1; h[i] = 1'b0; end
        end
      end
      if (clr) begin rl = m_held; h = '0; end
      if (valid && !ev[8] && !hit) un = 1'b1;
      if (valid) lc = {ev[9], ev[7:0]};
`ifdef KEY_AUTO_REPEAT_EN
      el = m_cyc - m_t0;
      if (m_rep_on && !clr && nw == '0 && !rl[m_tgt] && el >= DLY && ((el - DLY) % PER) == 0)
        p[m_tgt] = 1'b1;
      if (clr) m_rep_on = 1'b0;
      else if (nw != '0) begin
        for (int i = NK - 1; i >= 0; i--) if (nw[i]) m_tgt = i;
        m_t0 = m_cyc;
        m_rep_on = 1'b1;
      end else if (rl[m_tgt]) m_rep_on = 1'b0;
`else
      el = 0;
`endif
    end
    m_held = h;
    m_last = lc;
    sb.push_back({p, rl, h, |p, un, lc});
    rst = r;
    bus.clear_all = clr;
    bus.key_event = ev;
    @(posedge clk);
    #1;
    m_cyc++;
  endtask

  task automatic test_reset();
    stim_t seq [];
    seq = '{{1'b1, 1'b0, 11'h000, 8'd3}, {1'b0, 1'b0, 11'h000, 8'd2}};
    foreach (seq[k]) for (int j = 0; j < int'(seq[k].n); j++) begin
      cycle(seq[k].r, seq[k].clr, seq[k].ev);
      exp_v = sb.pop_front();
      checks++;
      if (obs !== exp_v) begin
        $display("FAIL reset step %0d.%0d: got %h expected %h", k, j, obs, exp_v);
        errors++;
      end
    end
  endtask

  task automatic test_press_release();
    stim_t seq [];
    seq = '{{1'b0, 1'b0, 11'h41D, 8'd1}, {1'b0, 1'b0, 11'h000, 8'd2},
            {1'b0, 1'b0, 11'h41D, 8'd1}, {1'b0, 1'b0, 11'h41D, 8'd1},
            {1'b0, 1'b0, 11'h41D, 8'd1}, {1'b0, 1'b0, 11'h000, 8'd1},
            {1'b0, 1'b0, 11'h51D, 8'd1}, {1'b0, 1'b0, 11'h000, 8'd2}};
    foreach (seq[k]) for (int j = 0; j < int'(seq[k].n); j++) begin
      cycle(seq[k].r, seq[k].clr, seq[k].ev);
      exp_v = sb.pop_front();
      checks++;
      if (obs !== exp_v) begin
        $display("FAIL press_release step %0d.%0d: got %h expected %h", k, j, obs, exp_v);
        errors++;
      end
      if (k == 0) begin
        checks++;
        if (bus.press !== 14'h0001 || bus.last_code !== 9'h01D) begin
          $display("FAIL press_w_direct: press=%h last=%h required press=0001 last=01d",
                   bus.press, bus.last_code);
          errors++;
        end
      end
      if (k == 6) begin
        checks++;
        if (bus.release_pulse !== 14'h0001 || bus.held !== 14'h0000) begin
          $display("FAIL release_w_direct: release=%h held=%h required 0001/0000",
                   bus.release_pulse, bus.held);
          errors++;
        end
      end
    end
  endtask

  task automatic test_ext_unmapped();
    stim_t seq [];
    seq = '{{1'b0, 1'b0, 11'h675, 8'd1}, {1'b0, 1'b0, 11'h000, 8'd1},
            {1'b0, 1'b0, 11'h775, 8'd1}, {1'b0, 1'b0, 11'h475, 8'd1},
            {1'b0, 1'b0, 11'h000, 8'd1}, {1'b0, 1'b0, 11'h51D, 8'd1},
            {1'b0, 1'b0, 11'h575, 8'd1}, {1'b0, 1'b0, 11'h0AA, 8'd1},
            {1'b0, 1'b0, 11'h000, 8'd1}};
    foreach (seq[k]) for (int j = 0; j < int'(seq[k].n); j++) begin
      cycle(seq[k].r, seq[k].clr, seq[k].ev);
      exp_v = sb.pop_front();
      checks++;
      if (obs !== exp_v) begin
        $display("FAIL ext_unmapped step %0d.%0d: got %h expected %h", k, j, obs, exp_v);
        errors++;
      end
      if (k == 3) begin
        checks++;
        if (bus.unmapped !== 1'b1 || bus.press !== 14'h0000) begin
          $display("FAIL unmapped_direct: unmapped=%b press=%h required 1/0000",
                   bus.unmapped, bus.press);
          errors++;
        end
      end
    end
  endtask

  task automatic test_clear_all();
    stim_t seq [];
    seq = '{{1'b0, 1'b0, 11'h41D, 8'd1}, {1'b0, 1'b0, 11'h675, 8'd1},
            {1'b0, 1'b0, 11'h429, 8'd1}, {1'b0, 1'b1, 11'h423, 8'd1},
            {1'b0, 1'b0, 11'h000, 8'd3}};
    foreach (seq[k]) for (int j = 0; j < int'(seq[k].n); j++) begin
      cycle(seq[k].r, seq[k].clr, seq[k].ev);
      exp_v = sb.pop_front();
      checks++;
      if (obs !== exp_v) begin
        $display("FAIL clear_all step %0d.%0d: got %h expected %h", k, j, obs, exp_v);
        errors++;
      end
      if (k == 3) begin
        checks++;
        if (bus.release_pulse !== 14'h0211 || bus.held !== 14'h0000 || bus.press !== 14'h0000) begin
          $display("FAIL clear_direct: release=%h held=%h press=%h required 0211/0000/0000",
                   bus.release_pulse, bus.held, bus.press);
          errors++;
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    stim_t seq [];
    seq = '{{1'b0, 1'b0, 11'h41B, 8'd1}, {1'b0, 1'b0, 11'h423, 8'd1},
            {1'b0, 1'b0, 11'h66B, 8'd1}, {1'b0, 1'b0, 11'h51B, 8'd1},
            {1'b0, 1'b0, 11'h523, 8'd1}, {1'b0, 1'b0, 11'h76B, 8'd1},
            {1'b0, 1'b0, 11'h000, 8'd2}};
    foreach (seq[k]) for (int j = 0; j < int'(seq[k].n); j++) begin
      cycle(seq[k].r, seq[k].clr, seq[k].ev);
      exp_v = sb.pop_front();
      checks++;
      if (obs !== exp_v) begin
        $display("FAIL back_to_back step %0d.%0d: got %h expected %h", k, j, obs, exp_v);
        errors++;
      end
    end
  endtask

  task automatic test_auto_repeat();
    stim_t seq [];
    int a_cnt = 0;
    int a_req;
    seq = '{{1'b0, 1'b0, 11'h41C, 8'd1}, {1'b0, 1'b0, 11'h000, 8'd19},
            {1'b0, 1'b0, 11'h423, 8'd1}, {1'b0, 1'b0, 11'h000, 8'd15},
            {1'b0, 1'b0, 11'h523, 8'd1}, {1'b0, 1'b0, 11'h000, 8'd12}};
    foreach (seq[k]) for (int j = 0; j < int'(seq[k].n); j++) begin
      cycle(seq[k].r, seq[k].clr, seq[k].ev);
      exp_v = sb.pop_front();
      checks++;
      if (obs !== exp_v) begin
        $display("FAIL auto_repeat step %0d.%0d: got %h expected %h", k, j, obs, exp_v);
        errors++;
      end
      if (bus.press[1] === 1'b1) a_cnt++;
    end
`ifdef KEY_AUTO_REPEAT_EN
    a_req = 4;
`else
    a_req = 1;
`endif
    checks++;
    if (a_cnt != a_req) begin
      $display("FAIL auto_repeat_a_count: got %0d required %0d", a_cnt, a_req);
      errors++;
    end
  endtask

  task automatic test_reset_mid_delay();
    stim_t seq [];
    seq = '{{1'b0, 1'b0, 11'h41D, 8'd1}, {1'b0, 1'b0, 11'h41B, 8'd1},
            {1'b0, 1'b0, 11'h000, 8'd3}, {1'b1, 1'b0, 11'h000, 8'd1},
            {1'b0, 1'b0, 11'h000, 8'd15}};
    foreach (seq[k]) for (int j = 0; j < int'(seq[k].n); j++) begin
      cycle(seq[k].r, seq[k].clr, seq[k].ev);
      exp_v = sb.pop_front();
      checks++;
      if (obs !== exp_v) begin
        $display("FAIL reset_mid step %0d.%0d: got %h expected %h", k, j, obs, exp_v);
        errors++;
      end
      if (k >= 3) begin
        checks++;
        if (obs !== 53'h0) begin
          $display("FAIL reset_mid_zero step %0d.%0d: got %h required 0", k, j, obs);
          errors++;
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.clear_all = 1'b0;
    bus.key_event = 11'h000;
    @(posedge clk);
    #1;
    test_reset();
    test_press_release();
    test_ext_unmapped();
    test_clear_all();
    test_back_to_back();
    test_auto_repeat();
    test_reset_mid_delay();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
